// File: rtl/ip_codma_task_queue.sv
// Descriptor FIFO and launcher for ip_codma_top: queues task/status pointer pairs
// and issues them one at a time over the CoDMA start/busy handshake.
module ip_codma_task_queue #(
  parameter int DEPTH         = 4,
  parameter int PTR_W         = 32,
  parameter int START_TIMEOUT = 16,
  parameter int CNT_W         = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_valid_i,
  output logic                       push_ready_o,
  input  logic [PTR_W-1:0]           push_task_ptr_i,
  input  logic [PTR_W-1:0]           push_status_ptr_i,
  input  logic                       flush_i,
  input  logic                       err_clr_i,
  output logic                       start_o,
  output logic                       stop_o,
  output logic [PTR_W-1:0]           task_pointer_o,
  output logic [PTR_W-1:0]           status_pointer_o,
  input  logic                       busy_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic [CNT_W-1:0]           done_count_o,
  output logic                       idle_o,
  output logic                       timeout_err_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int TO_W  = $clog2(START_TIMEOUT+1);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, GAP} state_t;

  state_t            state_q, state_n;
  logic [PTR_W-1:0]  task_mem   [DEPTH];
  logic [PTR_W-1:0]  status_mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_n, rd_ptr_q, rd_ptr_n;
  logic [LVL_W-1:0]  level_q, level_n;
  logic [TO_W-1:0]   tcnt_q, tcnt_n;
  logic [CNT_W-1:0]  done_q, done_n;
  logic [PTR_W-1:0]  tptr_q, tptr_n, sptr_q, sptr_n;
  logic              start_q, start_n, stop_q, stop_n;
  logic              err_q, err_n, err_set;
  logic              aborted_q, aborted_n;
  logic              idle_q, idle_n;
  logic              full, empty, push_fire, pop;

  assign full         = (level_q == LVL_W'(DEPTH));
  assign empty        = (level_q == '0);
  // No bypass: a full queue refuses the push even if it pops on the same edge.
  assign push_ready_o = !reset_i && !full && !flush_i;
  assign push_fire    = push_valid_i && push_ready_o;
  assign pop          = (state_q == IDLE) && !empty && !busy_i && !flush_i;

  always_comb begin
    state_n   = state_q;
    start_n   = start_q;
    stop_n    = 1'b0;
    tptr_n    = tptr_q;
    sptr_n    = sptr_q;
    tcnt_n    = tcnt_q;
    done_n    = done_q;
    aborted_n = aborted_q;
    err_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_n   = LAUNCH;
          start_n   = 1'b1;
          tptr_n    = task_mem[rd_ptr_q];
          sptr_n    = status_mem[rd_ptr_q];
          tcnt_n    = '0;
          aborted_n = 1'b0;
        end
      end
      LAUNCH: begin
        if (flush_i) begin
          start_n = 1'b0;
          state_n = GAP;
        end else if (busy_i) begin
          start_n = 1'b0;
          state_n = RUN;
          tcnt_n  = '0;
        end else if (tcnt_q == TO_W'(START_TIMEOUT - 1)) begin
          start_n = 1'b0;
          state_n = GAP;
          err_set = 1'b1;
        end else begin
          tcnt_n = tcnt_q + TO_W'(1);
        end
      end
      RUN: begin
        if (!busy_i) begin
          state_n = GAP;
          if (!aborted_q) done_n = done_q + CNT_W'(1);
        end else if (flush_i && !aborted_q) begin
          // One stop pulse per aborted task, even with flush held.
          stop_n    = 1'b1;
          aborted_n = 1'b1;
        end
      end
      default: begin
        state_n   = IDLE;
        aborted_n = 1'b0;
      end
    endcase

    err_n = err_set ? 1'b1 : (err_clr_i ? 1'b0 : err_q);

    wr_ptr_n = push_fire ? wr_ptr_q + AW'(1) : wr_ptr_q;
    if (flush_i) begin
      rd_ptr_n = wr_ptr_q;
      level_n  = '0;
    end else begin
      rd_ptr_n = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_n  = level_q;
      if (push_fire && !pop) level_n = level_q + LVL_W'(1);
      else if (!push_fire && pop) level_n = level_q - LVL_W'(1);
    end

    idle_n = (state_n == IDLE) && (level_n == '0);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      tcnt_q    <= '0;
      done_q    <= '0;
      tptr_q    <= '0;
      sptr_q    <= '0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      state_q   <= state_n;
      wr_ptr_q  <= wr_ptr_n;
      rd_ptr_q  <= rd_ptr_n;
      level_q   <= level_n;
      tcnt_q    <= tcnt_n;
      done_q    <= done_n;
      tptr_q    <= tptr_n;
      sptr_q    <= sptr_n;
      start_q   <= start_n;
      stop_q    <= stop_n;
      err_q     <= err_n;
      aborted_q <= aborted_n;
      idle_q    <= idle_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_fire) begin
      task_mem[wr_ptr_q]   <= push_task_ptr_i;
      status_mem[wr_ptr_q] <= push_status_ptr_i;
    end
  end

  assign start_o          = start_q;
  assign stop_o           = stop_q;
  assign task_pointer_o   = tptr_q;
  assign status_pointer_o = sptr_q;
  assign level_o          = level_q;
  assign done_count_o     = done_q;
  assign idle_o           = idle_q;
  assign timeout_err_o    = err_q;

endmodule
